// File: rtl/ff_regfile_mp.sv
// Multi-port flip-flop register file: one write/invalidate port, NRD registered read ports,
// per-entry valid bits, single-cycle error pulse and saturating error counter.
module ff_regfile_mp #(
  parameter int DW     = 8,
  parameter int DEPTH  = 8,
  parameter int AW     = $clog2(DEPTH),
  parameter int NRD    = 2,
  parameter int BYPASS = 0
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              wr,
  input  logic [AW-1:0]     waddr,
  input  logic [DW-1:0]     din,
  input  logic              clr,
  input  logic              clr_all,
  input  logic [NRD-1:0]    rd,
  input  logic [NRD*AW-1:0] raddr,
  output logic [NRD*DW-1:0] dout,
  output logic [NRD-1:0]    rvalid,
  output logic              error,
  output logic [7:0]        err_cnt
);

  logic [DW-1:0]     mem_q   [DEPTH];
  logic [DW-1:0]     mem_d   [DEPTH];
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [NRD*DW-1:0] dout_q, dout_d;
  logic [NRD-1:0]    rvalid_q, rvalid_d;
  logic              error_q, error_d;
  logic [7:0]        err_cnt_q, err_cnt_d;

  logic              w_in_range;
  logic              wr_ok, clr_ok, err_w;
  logic [NRD-1:0]    rd_err;
  logic [AW-1:0]     ra;
  logic              bypass_zero;

  // clr_all always wins; a colliding wr/clr is dropped and flagged.
  always_comb begin
    w_in_range = (32'(waddr) < DEPTH);
    wr_ok      = wr & ~clr & ~clr_all & w_in_range;
    clr_ok     = clr & ~wr & ~clr_all & w_in_range;
    err_w      = (clr_all & (wr | clr)) | (wr & clr) | ((wr | clr) & ~w_in_range);
  end

  always_comb begin
    mem_d   = mem_q;
    valid_d = valid_q;
    if (clr_all) begin
      for (int j = 0; j < DEPTH; j++) begin
        mem_d[j]   = '0;
        valid_d[j] = 1'b0;
      end
    end else if (wr_ok) begin
      mem_d[waddr]   = din;
      valid_d[waddr] = 1'b1;
    end else if (clr_ok) begin
      mem_d[waddr]   = '0;
      valid_d[waddr] = 1'b0;
    end
  end

  // With BYPASS set, reads observe the effective write-port operation of this cycle.
  always_comb begin
    dout_d      = '0;
    rvalid_d    = '0;
    rd_err      = '0;
    ra          = '0;
    bypass_zero = 1'b0;
    for (int i = 0; i < NRD; i++) begin
      ra          = raddr[i*AW +: AW];
      bypass_zero = (BYPASS != 0) && (clr_all || (clr_ok && (ra == waddr)));
      if (rd[i]) begin
        if (32'(ra) >= DEPTH) begin
          rd_err[i] = 1'b1;
        end else if (bypass_zero) begin
          rvalid_d[i] = 1'b0;
        end else if ((BYPASS != 0) && wr_ok && (ra == waddr)) begin
          dout_d[i*DW +: DW] = din;
          rvalid_d[i]        = 1'b1;
        end else if (valid_q[ra]) begin
          dout_d[i*DW +: DW] = mem_q[ra];
          rvalid_d[i]        = 1'b1;
        end
      end
    end
  end

  always_comb begin
    error_d   = err_w | (|rd_err);
    err_cnt_d = err_cnt_q;
    if (error_d && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int j = 0; j < DEPTH; j++) begin
        mem_q[j] <= '0;
      end
      valid_q   <= '0;
      dout_q    <= '0;
      rvalid_q  <= '0;
      error_q   <= 1'b0;
      err_cnt_q <= 8'd0;
    end else begin
      mem_q     <= mem_d;
      valid_q   <= valid_d;
      dout_q    <= dout_d;
      rvalid_q  <= rvalid_d;
      error_q   <= error_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign dout    = dout_q;
  assign rvalid  = rvalid_q;
  assign error   = error_q;
  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_ff_regfile_mp.sv
// Directed bench for ff_regfile_mp: instance a (DEPTH=8, BYPASS=0) and instance b
// (DEPTH=6, BYPASS=1) share stimulus; each observed as {dout, rvalid, error, err_cnt}.
module tb_ff_regfile_mp;

  logic       clk = 1'b0;
  logic       resetn;
  logic       wr, clr, clr_all;
  logic [2:0] waddr;
  logic [7:0] din;
  logic [1:0] rd;
  logic [5:0] raddr;

  logic [15:0] dout_a, dout_b;
  logic [1:0]  rvalid_a, rvalid_b;
  logic        error_a, error_b;
  logic [7:0]  err_cnt_a, err_cnt_b;

  wire [26:0] obs_a = {dout_a, rvalid_a, error_a, err_cnt_a};
  wire [26:0] obs_b = {dout_b, rvalid_b, error_b, err_cnt_b};

  int checks = 0;
  int errors = 0;
  logic [26:0] exp_a, exp_b;

  always #5 clk = ~clk;

  ff_regfile_mp #(.DW(8), .DEPTH(8), .NRD(2), .BYPASS(0)) u_a (
    .clk(clk), .resetn(resetn), .wr(wr), .waddr(waddr), .din(din), .clr(clr),
    .clr_all(clr_all), .rd(rd), .raddr(raddr), .dout(dout_a), .rvalid(rvalid_a),
    .error(error_a), .err_cnt(err_cnt_a)
  );

  ff_regfile_mp #(.DW(8), .DEPTH(6), .NRD(2), .BYPASS(1)) u_b (
    .clk(clk), .resetn(resetn), .wr(wr), .waddr(waddr), .din(din), .clr(clr),
    .clr_all(clr_all), .rd(rd), .raddr(raddr), .dout(dout_b), .rvalid(rvalid_b),
    .error(error_b), .err_cnt(err_cnt_b)
  );

  task automatic set_in(input logic w, input logic c, input logic ca, input logic [2:0] wa,
                        input logic [7:0] d, input logic [1:0] r, input logic [2:0] r0,
                        input logic [2:0] r1);
    wr = w; clr = c; clr_all = ca; waddr = wa; din = d; rd = r; raddr = {r1, r0};
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cmp(input string name);
    checks++;
    if (obs_a !== exp_a) begin
      errors++;
      $display("FAIL %s inst_a got %h expected %h", name, obs_a, exp_a);
    end
    checks++;
    if (obs_b !== exp_b) begin
      errors++;
      $display("FAIL %s inst_b got %h expected %h", name, obs_b, exp_b);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    set_in(0, 0, 0, 3'd0, 8'h00, 2'b00, 3'd0, 3'd0);
    #3;
    exp_a = '0; exp_b = '0;
    cmp("reset_state");
    #9 resetn = 1'b1;
    set_in(0, 0, 0, 3'd0, 8'h00, 2'b11, 3'd3, 3'd5);
    step();
    exp_a = {16'h0000, 2'b00, 1'b0, 8'd0}; exp_b = exp_a;
    cmp("read_unwritten");
  endtask

  task automatic test_write_read();
    set_in(1, 0, 0, 3'd2, 8'hA5, 2'b00, 3'd0, 3'd0);
    step();
    exp_a = '0; exp_b = '0;
    cmp("write_idle_out");
    set_in(0, 0, 0, 3'd0, 8'h00, 2'b11, 3'd2, 3'd2);
    step();
    exp_a = {16'hA5A5, 2'b11, 1'b0, 8'd0}; exp_b = exp_a;
    cmp("read_both_ports");
    set_in(0, 0, 0, 3'd0, 8'h00, 2'b00, 3'd2, 3'd2);
    step();
    exp_a = '0; exp_b = '0;
    cmp("no_stale_data");
    set_in(0, 1, 0, 3'd2, 8'h00, 2'b00, 3'd0, 3'd0);
    step();
    set_in(0, 0, 0, 3'd0, 8'h00, 2'b11, 3'd2, 3'd2);
    step();
    exp_a = '0; exp_b = '0;
    cmp("read_after_clr");
  endtask

  task automatic test_bypass();
    set_in(1, 0, 0, 3'd4, 8'h11, 2'b00, 3'd0, 3'd0);
    step();
    set_in(1, 0, 0, 3'd4, 8'h3C, 2'b01, 3'd4, 3'd0);
    step();
    exp_a = {16'h0011, 2'b01, 1'b0, 8'd0};
    exp_b = {16'h003C, 2'b01, 1'b0, 8'd0};
    cmp("same_cycle_wr_rd");
    set_in(0, 0, 0, 3'd0, 8'h00, 2'b01, 3'd4, 3'd0);
    step();
    exp_a = {16'h003C, 2'b01, 1'b0, 8'd0}; exp_b = exp_a;
    cmp("read_after_wr");
    set_in(0, 1, 0, 3'd4, 8'h00, 2'b01, 3'd4, 3'd0);
    step();
    exp_a = {16'h003C, 2'b01, 1'b0, 8'd0};
    exp_b = {16'h0000, 2'b00, 1'b0, 8'd0};
    cmp("same_cycle_clr_rd");
    set_in(0, 0, 0, 3'd0, 8'h00, 2'b01, 3'd4, 3'd0);
    step();
    exp_a = '0; exp_b = '0;
    cmp("read_after_clr4");
  endtask

  task automatic test_conflict();
    set_in(1, 0, 0, 3'd1, 8'h77, 2'b00, 3'd0, 3'd0);
    step();
    set_in(1, 1, 0, 3'd1, 8'h00, 2'b01, 3'd1, 3'd0);
    step();
    exp_a = {16'h0077, 2'b01, 1'b1, 8'd1}; exp_b = exp_a;
    cmp("wr_clr_conflict");
    set_in(0, 0, 0, 3'd0, 8'h00, 2'b11, 3'd1, 3'd1);
    step();
    exp_a = {16'h7777, 2'b11, 1'b0, 8'd1}; exp_b = exp_a;
    cmp("entry_kept");
    set_in(1, 0, 1, 3'd1, 8'h55, 2'b00, 3'd0, 3'd0);
    step();
    exp_a = {16'h0000, 2'b00, 1'b1, 8'd2}; exp_b = exp_a;
    cmp("clr_all_with_wr");
    set_in(0, 0, 0, 3'd0, 8'h00, 2'b11, 3'd1, 3'd4);
    step();
    exp_a = {16'h0000, 2'b00, 1'b0, 8'd2}; exp_b = exp_a;
    cmp("all_invalid");
  endtask

  task automatic test_range();
    set_in(1, 0, 0, 3'd7, 8'h99, 2'b00, 3'd0, 3'd0);
    step();
    exp_a = {16'h0000, 2'b00, 1'b0, 8'd2};
    exp_b = {16'h0000, 2'b00, 1'b1, 8'd3};
    cmp("wr_out_of_range");
    set_in(0, 0, 0, 3'd0, 8'h00, 2'b11, 3'd6, 3'd7);
    step();
    exp_a = {16'h9900, 2'b10, 1'b0, 8'd2};
    exp_b = {16'h0000, 2'b00, 1'b1, 8'd4};
    cmp("rd_out_of_range");
    set_in(0, 0, 0, 3'd0, 8'h00, 2'b01, 3'd6, 3'd0);
    repeat (300) step();
    exp_a = {16'h0000, 2'b00, 1'b0, 8'd2};
    exp_b = {16'h0000, 2'b00, 1'b1, 8'd255};
    cmp("err_cnt_saturate");
    set_in(0, 0, 0, 3'd0, 8'h00, 2'b00, 3'd0, 3'd0);
    step();
    exp_b = {16'h0000, 2'b00, 1'b0, 8'd255};
    cmp("err_cnt_hold");
  endtask

  task automatic test_reset_mid();
    set_in(1, 0, 0, 3'd3, 8'h42, 2'b00, 3'd0, 3'd0);
    step();
    set_in(0, 0, 0, 3'd0, 8'h00, 2'b11, 3'd3, 3'd3);
    step();
    exp_a = {16'h4242, 2'b11, 1'b0, 8'd2};
    exp_b = {16'h4242, 2'b11, 1'b0, 8'd255};
    cmp("pre_reset_read");
    #1 resetn = 1'b0;
    #1;
    exp_a = '0; exp_b = '0;
    cmp("async_reset");
    @(negedge clk);
    resetn = 1'b1;
    set_in(0, 0, 0, 3'd0, 8'h00, 2'b11, 3'd3, 3'd7);
    step();
    exp_a = {16'h0000, 2'b00, 1'b0, 8'd0};
    exp_b = {16'h0000, 2'b00, 1'b1, 8'd1};
    cmp("post_reset_invalid");
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_conflict();
    test_range();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
